serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor. Computes D = A - B - bin over WIDTH clock cycles using a single full-subtractor cell and a borrow flip-flop.
- Serves as the area-lean inverse counterpart to the team's parallel lookahead adders in the datapath library. It is used where throughput is not critical.
- Operands are captured on a start handshake. Results are registered and held until the next completed operation.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled at the accepting edge only.
- B  input  WIDTH  subtrahend; sampled at the accepting edge only.
- bin  input  1  borrow-in; sampled at the accepting edge only.
- busy  output  1  high while a subtraction is shifting.
- done  output  1  one-cycle completion pulse.
- D  output  WIDTH  difference, registered.
- Bo  output  1  borrow-out (1 = unsigned A < B + bin).
- Z  output  1  D == 0.
- V  output  1  two's-complement signed overflow.

Behaviour:
- Reset, asynchronous, any state:
  - State goes to IDLE.
  - Shift registers, borrow FF and counter clear to 0.
  - busy, done, D, Bo, Z, V all go to 0 immediately.
  - Reset mid-operation aborts the operation; no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: load A, B into right-shift registers; load bin into the borrow FF; latch A[WIDTH-1], B[WIDTH-1]; clear the counter; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT: busy=1. On each edge:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the result register MSB; shift the A and B registers right by 1; increment the counter.
  - After the WIDTH-th shift edge: go to DONE; at that same edge load D, Bo (= final borrow), Z and V.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally. start during DONE is ignored.
- Latency: start accepted at edge k; D/Bo/Z/V valid and done high between edges k+WIDTH and k+WIDTH+1. Next start can be accepted at edge k+WIDTH+2 at the earliest.
- Output hold: D/Bo/Z/V hold their last values through IDLE and through the next SHIFT phase. They change only at completion or on reset.
- V = (Amsb ^ Bmsb) & (D[WIDTH-1] ^ Amsb), using the latched operand MSBs.
- Z = ~|D, computed from the final result value.
- start while busy or in DONE: ignored; operands are not re-sampled and there is no effect on the in-flight result.
- A, B and bin may change freely after the accepting edge without affecting the result.
- Counter width: clog2(WIDTH)+1 bits. It wraps to 0 on return to IDLE.

Test Plan (WIDTH=8):
- A=8'h5A, B=8'h3C, bin=0, start pulse -> busy for 8 cycles, then done 1 cycle; D=8'h1E, Bo=0, Z=0, V=0; done rises exactly 8 edges after the accepting edge.
- A=8'h10, B=8'h20, bin=0 -> D=8'hF0, Bo=1, Z=0, V=0.
- A=8'h80, B=8'h01, bin=0 -> D=8'h7F, Bo=0, V=1.
- A=8'h37, B=8'h36, bin=1 -> D=8'h00, Z=1, Bo=0, V=0. Then A=8'h00, B=8'hFF, bin=1 -> D=8'h00, Bo=1, Z=1, V=0.
- Start 8'h5A-8'h3C; pulse start with A=8'hFF, B=8'h00 at shift cycle 3 and again during DONE -> result still 8'h1E; only one done pulse; FSM returns to IDLE.
- Start an operation; assert rst asynchronously (mid-cycle) at shift cycle 4 -> busy, done, D, Bo, Z, V go to 0 without waiting for a clock edge; no done pulse. After deassert, 8'h5A-8'h3C completes normally with D=8'h1E.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial, LSB-first subtractor. It computes D = A - B - bin over WIDTH
// clock cycles. A single full-subtractor cell and a borrow flip-flop do the
// arithmetic. It is the low-area counterpart of the parallel adders, for
// datapaths where throughput does not matter.
//
// Handshake (start/busy/done):
//   start is sampled only in IDLE. The edge that sees start=1 is the accepting
//   edge: A, B and bin are captured there and never looked at again. busy is
//   high for the WIDTH shift cycles. done is a single-cycle pulse that follows.
//   D/Bo/Z/V are valid from the start of that pulse and hold until the next
//   completed operation or a reset. start seen in SHIFT or DONE is ignored.
//
// Ports:
//   clk    in   system clock, rising-edge
//   rst    in   asynchronous active-high reset (aborts any operation)
//   start  in   operation request
//   A      in   [WIDTH-1:0] minuend
//   B      in   [WIDTH-1:0] subtrahend
//   bin    in   borrow-in
//   busy   out  high while shifting
//   done   out  one-cycle completion pulse
//   D      out  [WIDTH-1:0] registered difference
//   Bo     out  borrow-out (1 = unsigned A < B + bin)
//   Z      out  D == 0
//   V      out  two's-complement signed overflow
//   state  out  [1:0] FSM state for observation (00 IDLE, 01 SHIFT, 10 DONE)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             Z,
    output logic             V,
    output logic [1:0]       state
);

    // One extra counter bit lets the count reach WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    // Operand and partial-result shift registers
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    // Operand sign bits captured at accept time, used for overflow at the end
    logic             amsb;
    logic             bmsb;

    // Full-subtractor cell and derived values
    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             br_next;
    logic             last_shift;
    logic [WIDTH-1:0] d_final;

    always_comb begin
        a0         = a_sr[0];
        b0         = b_sr[0];
        d_bit      = a0 ^ b0 ^ br;
        br_next    = (~a0 & b0) | (~(a0 ^ b0) & br);
        // Result bits enter at the MSB. After WIDTH shifts the first
        // (least significant) bit has reached position 0.
        d_final    = {d_bit, d_sr[WIDTH-1:1]};
        last_shift = (cnt == LAST_CNT);
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and status outputs
    // -------------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        busy      = 1'b0;
        done      = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start) begin
                    nxt_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) begin
                    nxt_state = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    assign state = cur_state;

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            amsb <= 1'b0;
            bmsb <= 1'b0;
            D    <= '0;
            Bo   <= 1'b0;
            Z    <= 1'b0;
            V    <= 1'b0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        d_sr <= '0;
                        br   <= bin;
                        amsb <= A[WIDTH-1];
                        bmsb <= B[WIDTH-1];
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    d_sr <= d_final;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    // The visible outputs change only here, so they hold the
                    // previous result for the whole shift phase.
                    if (last_shift) begin
                        D  <= d_final;
                        Bo <= br_next;
                        Z  <= ~|d_final;
                        // Overflow: operand signs differ and the result sign
                        // differs from the minuend's.
                        V  <= (amsb ^ bmsb) & (d_final[WIDTH-1] ^ amsb);
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int RW = WIDTH + 3;  // {D, Bo, Z, V}
  localparam logic [1:0] ST_IDLE = 2'b00;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic bin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] D;
  logic Bo;
  logic Z;
  logic V;
  logic [1:0] state;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .bin(bin),
    .busy(busy),
    .done(done),
    .D(D),
    .Bo(Bo),
    .Z(Z),
    .V(V),
    .state(state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [RW-1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference: a WIDTH+1 bit subtraction gives the borrow directly in the top bit.
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic bi);
    logic [WIDTH:0] full;
    logic [WIDTH-1:0] d;
    logic v;
    full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
    d = full[WIDTH-1:0];
    v = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    return {d, full[WIDTH], (d == '0), v};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Present one request and return just after its accepting edge. Inputs are
  // then scrambled to show they are not re-sampled.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                          input logic [RW-1:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    bin = bi;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    A = WIDTH'($urandom_range(0, 255));
    B = WIDTH'($urandom_range(0, 255));
    bin = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for done. edges counts rising edges since the accepting edge.
  task automatic wait_done(output int edges, output int busy_bad);
    edges = 0;
    busy_bad = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (!done && !busy) busy_bad++;
    end while (!done && edges < 40);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    bin = 1'b0;
    #2;
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_status busy/done=%b expected 00", {busy, done});
    else pass_cnt++;
    total_cnt++;
    if ({D, Bo, Z, V} !== '0) $display("FAIL reset_outputs {D,Bo,Z,V}=%h expected 0", {D, Bo, Z, V});
    else pass_cnt++;
    total_cnt++;
    if (state !== ST_IDLE) $display("FAIL reset_state state=%b expected %b", state, ST_IDLE);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, state} !== {2'b00, ST_IDLE})
      $display("FAIL idle_after_reset busy/done/state=%b expected 0000", {busy, done, state});
    else pass_cnt++;
  endtask

  task automatic test_vectors();
    logic [WIDTH-1:0] va[5];
    logic [WIDTH-1:0] vb[5];
    logic vbi[5];
    logic [RW-1:0] vexp[5];
    logic [RW-1:0] exp;
    int edges;
    int busy_bad;
    va[0] = 8'h5A; vb[0] = 8'h3C; vbi[0] = 1'b0; vexp[0] = {8'h1E, 1'b0, 1'b0, 1'b0};
    va[1] = 8'h10; vb[1] = 8'h20; vbi[1] = 1'b0; vexp[1] = {8'hF0, 1'b1, 1'b0, 1'b0};
    va[2] = 8'h80; vb[2] = 8'h01; vbi[2] = 1'b0; vexp[2] = {8'h7F, 1'b0, 1'b0, 1'b1};
    va[3] = 8'h37; vb[3] = 8'h36; vbi[3] = 1'b1; vexp[3] = {8'h00, 1'b0, 1'b1, 1'b0};
    va[4] = 8'h00; vb[4] = 8'hFF; vbi[4] = 1'b1; vexp[4] = {8'h00, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vbi[i], vexp[i]);
      wait_done(edges, busy_bad);
      exp = '1;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      total_cnt++;
      if (edges !== WIDTH || !done)
        $display("FAIL vec%0d_latency done_edge=%0d done=%b expected edge %0d", i, edges, done, WIDTH);
      else pass_cnt++;
      total_cnt++;
      if (busy_bad !== 0) $display("FAIL vec%0d_busy busy low %0d cycles expected 0", i, busy_bad);
      else pass_cnt++;
      total_cnt++;
      if ({D, Bo, Z, V} !== exp)
        $display("FAIL vec%0d_result {D,Bo,Z,V}=%h expected %h", i, {D, Bo, Z, V}, exp);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if ({done, busy, state} !== {2'b00, ST_IDLE})
        $display("FAIL vec%0d_done_pulse done/busy/state=%b expected 0000", i, {done, busy, state});
      else pass_cnt++;
      // Result must hold through idle cycles.
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({D, Bo, Z, V} !== exp)
        $display("FAIL vec%0d_hold {D,Bo,Z,V}=%h expected %h", i, {D, Bo, Z, V}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored();
    logic [RW-1:0] exp;
    int done_cnt;
    int done_edge;
    exp = '1;
    done_cnt = 0;
    done_edge = 0;
    start_op(8'h5A, 8'h3C, 1'b0, {8'h1E, 1'b0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    // Pulse start with different operands during shift cycle 3.
    @(negedge clk);
    start = 1'b1;
    A = 8'hFF;
    B = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_edge = 4 + i;
          if (exp_q.size() > 0) exp = exp_q.pop_front();
          total_cnt++;
          if ({D, Bo, Z, V} !== exp)
            $display("FAIL ignore_result {D,Bo,Z,V}=%h expected %h", {D, Bo, Z, V}, exp);
          else pass_cnt++;
        end
        // Start held high through the DONE cycle.
        start = 1'b1;
        A = 8'hFF;
        B = 8'h00;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL ignore_done_count dones=%0d expected 1", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (done_edge !== WIDTH) $display("FAIL ignore_latency done_edge=%0d expected %0d", done_edge, WIDTH);
    else pass_cnt++;
    total_cnt++;
    if ({busy, state} !== {1'b0, ST_IDLE}) $display("FAIL ignore_idle busy/state=%b expected 000", {busy, state});
    else pass_cnt++;
    total_cnt++;
    if ({D, Bo, Z, V} !== exp) $display("FAIL ignore_hold {D,Bo,Z,V}=%h expected %h", {D, Bo, Z, V}, exp);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [RW-1:0] exp;
    int done_seen;
    int edges;
    int busy_bad;
    exp = '1;
    done_seen = 0;
    start_op(8'h5A, 8'h3C, 1'b0, {8'h1E, 1'b0, 1'b0, 1'b0});
    exp_q.delete();  // this operation will be aborted
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, state} !== 4'b0000)
      $display("FAIL async_rst_status busy/done/state=%b expected 0000", {busy, done, state});
    else pass_cnt++;
    total_cnt++;
    if ({D, Bo, Z, V} !== '0) $display("FAIL async_rst_outputs {D,Bo,Z,V}=%h expected 0", {D, Bo, Z, V});
    else pass_cnt++;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    total_cnt++;
    if (done_seen !== 0) $display("FAIL async_rst_no_done dones=%0d expected 0", done_seen);
    else pass_cnt++;
    start_op(8'h5A, 8'h3C, 1'b0, {8'h1E, 1'b0, 1'b0, 1'b0});
    wait_done(edges, busy_bad);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    total_cnt++;
    if (!done || edges !== WIDTH) $display("FAIL async_rst_recover done=%b edge=%0d expected edge %0d", done, edges, WIDTH);
    else pass_cnt++;
    total_cnt++;
    if ({D, Bo, Z, V} !== exp) $display("FAIL async_rst_result {D,Bo,Z,V}=%h expected %h", {D, Bo, Z, V}, exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] prev;
    logic [RW-1:0] exp;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic bi;
    int edges;
    int busy_bad;
    prev = {D, Bo, Z, V};  // known from the previous test's checked result
    // Align: the previous test ended just after its done cycle was sampled.
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      a = WIDTH'($urandom_range(0, 255));
      b = WIDTH'($urandom_range(0, 255));
      bi = 1'($urandom_range(0, 1));
      if (i == 0) begin
        a = 8'h7F;  // positive - negative overflow corner
        b = 8'hFF;
        bi = 1'b0;
      end
      start_op(a, b, bi, model(a, b, bi));
      total_cnt++;
      if ({D, Bo, Z, V} !== prev)
        $display("FAIL b2b%0d_hold_in_shift {D,Bo,Z,V}=%h expected %h", i, {D, Bo, Z, V}, prev);
      else pass_cnt++;
      wait_done(edges, busy_bad);
      exp = '1;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      total_cnt++;
      if (!done || edges !== WIDTH || busy_bad !== 0)
        $display("FAIL b2b%0d_timing done=%b edge=%0d busy_bad=%0d expected edge %0d", i, done, edges,
                 busy_bad, WIDTH);
      else pass_cnt++;
      total_cnt++;
      if ({D, Bo, Z, V} !== exp)
        $display("FAIL b2b%0d_result a=%h b=%h bin=%b {D,Bo,Z,V}=%h expected %h", i, a, b, bi,
                 {D, Bo, Z, V}, exp);
      else pass_cnt++;
      prev = exp;
      // Earliest next accept: one edge into IDLE, then start_op's edge.
      @(posedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_vectors();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_empty left=%0d expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
